// File: rtl/forwarding_hazard_unit.sv
// Data-hazard resolver for the 5-stage MIPS32 pipeline: stalls and bypass selects.
// Define HAZARD_STATS_EN to add saturating stall/forward event counters.
module forwarding_hazard_unit (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] sig_hazards,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] ex_rt_rd,
  input  logic [4:0] me_rt_rd,
  input  logic [4:0] wb_rt_rd,
  input  logic       ex_jump_link,
  input  logic       ex_reg_write,
  input  logic       me_reg_write,
  input  logic       wb_reg_write,
  input  logic       me_mem_read,
  input  logic       me_mem_write,
  input  logic       me_mem_to_reg,
  output logic       id_stall,
  output logic       ex_stall,
  output logic [1:0] id_fwd_rs_sel,
  output logic [1:0] id_fwd_rt_sel,
  output logic [1:0] ex_fwd_rs_sel,
  output logic [1:0] ex_fwd_rt_sel,
  output logic       me_write_data_fwd_sel
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stat_id_stalls,
  output logic [31:0] stat_ex_stalls,
  output logic [31:0] stat_fwd_events
`endif
);

  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst,
                                     input logic wr);
    return (src != 5'd0) && (src == dst) && wr;
  endfunction

  // ME is the youngest producer, so it wins over WB when both hold the register.
  function automatic logic [1:0] bypass_sel(input logic me_hit, input logic wb_hit);
    if (me_hit) return 2'b01;
    if (wb_hit) return 2'b10;
    return 2'b00;
  endfunction

  logic need_id_rs, need_id_rt, need_ex_rs, need_ex_rt;
  logic use_id_rs, use_id_rt, use_ex_rs, use_ex_rt;
  logic me_load, me_fwd_ok;
  logic m_idex_rs, m_idex_rt, m_idme_rs, m_idme_rt, m_idwb_rs, m_idwb_rt;
  logic m_exme_rs, m_exme_rt, m_exwb_rs, m_exwb_rt;
  logic ex_stall_raw, id_stall_raw;

  assign need_id_rs = sig_hazards[6];
  assign need_id_rt = sig_hazards[4];
  assign need_ex_rs = sig_hazards[2];
  assign need_ex_rt = sig_hazards[0];
  assign use_id_rs  = sig_hazards[7] | sig_hazards[6];
  assign use_id_rt  = sig_hazards[5] | sig_hazards[4];
  assign use_ex_rs  = sig_hazards[3] | sig_hazards[2];
  assign use_ex_rt  = sig_hazards[1] | sig_hazards[0];

  assign me_load   = (me_mem_read | me_mem_to_reg) & ~me_mem_write;
  assign me_fwd_ok = ~me_mem_read & ~me_mem_write;

  assign m_idex_rs = reg_match(id_rs, ex_rt_rd, ex_reg_write) & use_id_rs;
  assign m_idex_rt = reg_match(id_rt, ex_rt_rd, ex_reg_write) & use_id_rt;
  assign m_idme_rs = reg_match(id_rs, me_rt_rd, me_reg_write) & use_id_rs;
  assign m_idme_rt = reg_match(id_rt, me_rt_rd, me_reg_write) & use_id_rt;
  assign m_idwb_rs = reg_match(id_rs, wb_rt_rd, wb_reg_write) & use_id_rs;
  assign m_idwb_rt = reg_match(id_rt, wb_rt_rd, wb_reg_write) & use_id_rt;
  assign m_exme_rs = reg_match(ex_rs, me_rt_rd, me_reg_write) & use_ex_rs;
  assign m_exme_rt = reg_match(ex_rt, me_rt_rd, me_reg_write) & use_ex_rt;
  assign m_exwb_rs = reg_match(ex_rs, wb_rt_rd, wb_reg_write) & use_ex_rs;
  assign m_exwb_rt = reg_match(ex_rt, wb_rt_rd, wb_reg_write) & use_ex_rt;

  // A load in ME cannot be bypassed this cycle; anything in EX cannot be bypassed to ID at all.
  assign ex_stall_raw = (m_exme_rs & need_ex_rs & me_load) | (m_exme_rt & need_ex_rt & me_load);
  assign id_stall_raw = ex_stall_raw
                      | (m_idex_rs & need_id_rs) | (m_idex_rt & need_id_rt)
                      | (m_idme_rs & need_id_rs & me_load) | (m_idme_rt & need_id_rt & me_load);

  always_comb begin
    id_stall              = 1'b0;
    ex_stall              = 1'b0;
    id_fwd_rs_sel         = 2'b00;
    id_fwd_rt_sel         = 2'b00;
    ex_fwd_rs_sel         = 2'b00;
    ex_fwd_rt_sel         = 2'b00;
    me_write_data_fwd_sel = 1'b0;
    if (!reset) begin
      id_stall      = id_stall_raw;
      ex_stall      = ex_stall_raw;
      id_fwd_rs_sel = bypass_sel(m_idme_rs & me_fwd_ok, m_idwb_rs);
      id_fwd_rt_sel = bypass_sel(m_idme_rt & me_fwd_ok, m_idwb_rt);
      if (ex_jump_link) begin
        ex_fwd_rs_sel = 2'b11;
        ex_fwd_rt_sel = 2'b11;
      end else begin
        ex_fwd_rs_sel = bypass_sel(m_exme_rs & me_fwd_ok, m_exwb_rs);
        ex_fwd_rt_sel = bypass_sel(m_exme_rt & me_fwd_ok, m_exwb_rt);
      end
      me_write_data_fwd_sel = reg_match(me_rt_rd, wb_rt_rd, wb_reg_write);
    end
  end

`ifdef HAZARD_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic en);
    if (en && (cnt != 32'hFFFF_FFFF)) return cnt + 32'd1;
    return cnt;
  endfunction

  logic [31:0] id_stalls_q, id_stalls_d;
  logic [31:0] ex_stalls_q, ex_stalls_d;
  logic [31:0] fwd_events_q, fwd_events_d;
  logic        fwd_event;

  // Link selects (11) are not data bypasses and are not counted.
  assign fwd_event = (id_fwd_rs_sel != 2'b00) | (id_fwd_rt_sel != 2'b00)
                   | (ex_fwd_rs_sel == 2'b01) | (ex_fwd_rs_sel == 2'b10)
                   | (ex_fwd_rt_sel == 2'b01) | (ex_fwd_rt_sel == 2'b10);

  always_comb begin
    id_stalls_d  = sat_inc(id_stalls_q, id_stall);
    ex_stalls_d  = sat_inc(ex_stalls_q, ex_stall);
    fwd_events_d = sat_inc(fwd_events_q, fwd_event);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_stalls_q  <= 32'd0;
      ex_stalls_q  <= 32'd0;
      fwd_events_q <= 32'd0;
    end else begin
      id_stalls_q  <= id_stalls_d;
      ex_stalls_q  <= ex_stalls_d;
      fwd_events_q <= fwd_events_d;
    end
  end

  assign stat_id_stalls  = id_stalls_q;
  assign stat_ex_stalls  = ex_stalls_q;
  assign stat_fwd_events = fwd_events_q;
`else
  logic unused_clock;
  assign unused_clock = clock;
`endif

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Bench for forwarding_hazard_unit: directed table, async-reset sequence, randomized model check.
module tb_forwarding_hazard_unit;

  typedef struct packed {
    logic       rst;
    logic [7:0] sig;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, me_rd, wb_rd;
    logic       jl, ex_wr, me_wr, wb_wr, mr, mw, m2r;
  } in_t;

  typedef struct packed {
    logic       id_stall, ex_stall;
    logic [1:0] idrs, idrt, exrs, exrt;
    logic       mwd;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  e;
  } vec_t;

  logic        clock;
  logic        reset;
  logic [7:0]  sig_hazards;
  logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rt_rd, me_rt_rd, wb_rt_rd;
  logic        ex_jump_link, ex_reg_write, me_reg_write, wb_reg_write;
  logic        me_mem_read, me_mem_write, me_mem_to_reg;
  logic        id_stall, ex_stall, me_write_data_fwd_sel;
  logic [1:0]  id_fwd_rs_sel, id_fwd_rt_sel, ex_fwd_rs_sel, ex_fwd_rt_sel;
`ifdef HAZARD_STATS_EN
  logic [31:0] stat_id_stalls, stat_ex_stalls, stat_fwd_events;
`endif

  int tests = 0;
  int fails = 0;

  forwarding_hazard_unit dut (
    .clock(clock), .reset(reset), .sig_hazards(sig_hazards),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rt_rd(ex_rt_rd), .me_rt_rd(me_rt_rd), .wb_rt_rd(wb_rt_rd),
    .ex_jump_link(ex_jump_link), .ex_reg_write(ex_reg_write),
    .me_reg_write(me_reg_write), .wb_reg_write(wb_reg_write),
    .me_mem_read(me_mem_read), .me_mem_write(me_mem_write), .me_mem_to_reg(me_mem_to_reg),
    .id_stall(id_stall), .ex_stall(ex_stall),
    .id_fwd_rs_sel(id_fwd_rs_sel), .id_fwd_rt_sel(id_fwd_rt_sel),
    .ex_fwd_rs_sel(ex_fwd_rs_sel), .ex_fwd_rt_sel(ex_fwd_rt_sel),
    .me_write_data_fwd_sel(me_write_data_fwd_sel)
`ifdef HAZARD_STATS_EN
    ,
    .stat_id_stalls(stat_id_stalls), .stat_ex_stalls(stat_ex_stalls),
    .stat_fwd_events(stat_fwd_events)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: each source looks up the youngest stage holding its register.
  // Stage index 0=EX, 1=ME, 2=WB; source index 0=id_rs, 1=id_rt, 2=ex_rs, 3=ex_rt.
  function automatic out_t model(input in_t v);
    out_t       o;
    logic [4:0] dst [3];
    logic       wr  [3];
    logic [4:0] src [4];
    logic [1:0] sel [4];
    logic       hit [3];
    logic       need, want, load, bypass_ok;
    o = '0;
    if (v.rst) return o;
    dst = '{v.ex_rd, v.me_rd, v.wb_rd};
    wr  = '{v.ex_wr, v.me_wr, v.wb_wr};
    src = '{v.id_rs, v.id_rt, v.ex_rs, v.ex_rt};
    load      = (v.mr || v.m2r) && !v.mw;
    bypass_ok = !v.mr && !v.mw;
    for (int k = 0; k < 4; k++) begin
      want = v.sig[7 - 2*k];
      need = v.sig[6 - 2*k];
      for (int s = 0; s < 3; s++)
        hit[s] = (want || need) && src[k] != 0 && src[k] == dst[s] && wr[s];
      if (k >= 2) hit[0] = 1'b0;
      if (hit[1] && need && load) begin
        if (k >= 2) o.ex_stall = 1'b1;
        o.id_stall = 1'b1;
      end
      if (hit[0] && need) o.id_stall = 1'b1;
      sel[k] = (hit[1] && bypass_ok) ? 2'd1 : hit[2] ? 2'd2 : 2'd0;
      if (k >= 2 && v.jl) sel[k] = 2'd3;
    end
    o.idrs = sel[0];
    o.idrt = sel[1];
    o.exrs = sel[2];
    o.exrt = sel[3];
    o.mwd  = v.me_rd != 0 && v.me_rd == v.wb_rd && v.wb_wr;
    return o;
  endfunction

  task automatic drive(input in_t v);
    reset = v.rst; sig_hazards = v.sig;
    id_rs = v.id_rs; id_rt = v.id_rt; ex_rs = v.ex_rs; ex_rt = v.ex_rt;
    ex_rt_rd = v.ex_rd; me_rt_rd = v.me_rd; wb_rt_rd = v.wb_rd;
    ex_jump_link = v.jl; ex_reg_write = v.ex_wr; me_reg_write = v.me_wr;
    wb_reg_write = v.wb_wr; me_mem_read = v.mr; me_mem_write = v.mw; me_mem_to_reg = v.m2r;
  endtask

  function automatic out_t dut_out();
    return {id_stall, ex_stall, id_fwd_rs_sel, id_fwd_rt_sel,
            ex_fwd_rs_sel, ex_fwd_rt_sel, me_write_data_fwd_sel};
  endfunction

  task automatic check(input string name, input out_t act, input out_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got ids=%b exs=%b idrs=%b idrt=%b exrs=%b exrt=%b mwd=%b, expected ids=%b exs=%b idrs=%b idrt=%b exrs=%b exrt=%b mwd=%b",
               name, act.id_stall, act.ex_stall, act.idrs, act.idrt, act.exrs, act.exrt, act.mwd,
               exp.id_stall, exp.ex_stall, exp.idrs, exp.idrt, exp.exrs, exp.exrt, exp.mwd);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic out_t mk_out(input logic ids, input logic exs, input logic [1:0] a,
                                  input logic [1:0] b, input logic [1:0] c,
                                  input logic [1:0] d, input logic m);
    return {ids, exs, a, b, c, d, m};
  endfunction

  function automatic in_t all_wr(input in_t v);
    in_t r;
    r = v;
    r.ex_wr = 1'b1; r.me_wr = 1'b1; r.wb_wr = 1'b1;
    return r;
  endfunction

  vec_t tbl[$];
  in_t  v, v_stall, v_fwd;

  initial begin
    // Directed table
    v = '0; v.rst = 1; v.sig = 8'hFF; v.id_rs = 1; v.ex_rd = 1; v.jl = 1; v = all_wr(v);
    tbl.push_back('{"reset_forces_zero", v, mk_out(0, 0, 0, 0, 0, 0, 0)});
    v = '0; v.sig = 8'hF0; v.id_rs = 1; v.id_rt = 2; v.ex_rd = 1; v = all_wr(v);
    tbl.push_back('{"id_stall_ex_dep", v, mk_out(1, 0, 0, 0, 0, 0, 0)});
    v_stall = v;
    v = '0; v.sig = 8'hF0; v.id_rs = 1; v.id_rt = 2; v.ex_rd = 3; v.me_rd = 1; v.wb_rd = 2; v = all_wr(v);
    tbl.push_back('{"id_fwd_me_wb", v, mk_out(0, 0, 1, 2, 0, 0, 0)});
    v_fwd = v;
    v.me_rd = 2; v.wb_rd = 1;
    tbl.push_back('{"id_fwd_wb_me", v, mk_out(0, 0, 2, 1, 0, 0, 0)});
    v = '0; v.sig = 8'h0F; v.ex_rs = 1; v.ex_rt = 2; v.me_rd = 1; v.wb_rd = 2; v = all_wr(v);
    tbl.push_back('{"ex_fwd_me_wb", v, mk_out(0, 0, 0, 0, 1, 2, 0)});
    v.me_rd = 2; v.wb_rd = 1;
    tbl.push_back('{"ex_fwd_wb_me", v, mk_out(0, 0, 0, 0, 2, 1, 0)});
    v = '0; v.me_rd = 1; v.wb_rd = 1; v.wb_wr = 1;
    tbl.push_back('{"store_data_fwd", v, mk_out(0, 0, 0, 0, 0, 0, 1)});
    v = '0; v.sig = 8'h0F; v.ex_rs = 1; v.me_rd = 1; v.me_wr = 1; v.mr = 1;
    tbl.push_back('{"load_use_ex_stall", v, mk_out(1, 1, 0, 0, 0, 0, 0)});
    v.mr = 0; v.mw = 1; v.me_wr = 0;
    tbl.push_back('{"store_no_stall", v, mk_out(0, 0, 0, 0, 0, 0, 0)});
    v = '0; v.jl = 1;
    tbl.push_back('{"jump_link", v, mk_out(0, 0, 0, 0, 3, 3, 0)});
    v = '0; v.sig = 8'hFF; v = all_wr(v);
    tbl.push_back('{"reg0_no_hazard", v, mk_out(0, 0, 0, 0, 0, 0, 0)});
    v = '0; v.sig = 8'hA0; v.id_rs = 1; v.ex_rd = 1; v.ex_wr = 1;
    tbl.push_back('{"want_only_no_stall", v, mk_out(0, 0, 0, 0, 0, 0, 0)});
    v = '0; v.sig = 8'h0A; v.ex_rs = 1; v.me_rd = 1; v.me_wr = 1;
    tbl.push_back('{"want_only_forwards", v, mk_out(0, 0, 0, 0, 1, 0, 0)});
    v = '0; v.sig = 8'h0F; v.ex_rs = 3; v.me_rd = 3; v.wb_rd = 3; v = all_wr(v);
    tbl.push_back('{"me_beats_wb", v, mk_out(0, 0, 0, 0, 1, 0, 1)});
    v = '0; v.sig = 8'h40; v.id_rs = 4; v.me_rd = 4; v.me_wr = 1; v.m2r = 1;
    tbl.push_back('{"id_load_stall", v, mk_out(1, 0, 1, 0, 0, 0, 0)});
    v = '0; v.sig = 8'h0C; v.ex_rs = 5; v.me_rd = 5; v.wb_rd = 5; v.mr = 1; v = all_wr(v);
    tbl.push_back('{"load_falls_back_wb", v, mk_out(1, 1, 0, 0, 2, 0, 1)});

    v = '0; v.rst = 1;
    drive(v);
    #1;
    check("reset_state", dut_out(), '0);

`ifdef HAZARD_STATS_EN
    check32("stat_id_reset", stat_id_stalls, 32'd0);
    @(negedge clock);
    drive(v_stall);
    repeat (3) @(negedge clock);
    drive(v_fwd);
    repeat (2) @(negedge clock);
    v = '0;
    drive(v);
    #1;
    check32("stat_id_stalls", stat_id_stalls, 32'd3);
    check32("stat_ex_stalls", stat_ex_stalls, 32'd0);
    check32("stat_fwd_events", stat_fwd_events, 32'd2);
`endif

    foreach (tbl[n]) begin
      @(negedge clock);
      drive(tbl[n].i);
      #1;
      check(tbl[n].name, dut_out(), tbl[n].e);
    end

    // Async reset mid-cycle clears outputs immediately and releases cleanly
    @(negedge clock);
    v = v_fwd;
    drive(v);
    #1;
    check("pre_async_reset", dut_out(), mk_out(0, 0, 1, 2, 0, 0, 0));
    #1 reset = 1'b1;
    #1;
    check("async_reset_asserted", dut_out(), '0);
    #1 reset = 1'b0;
    #1;
    check("async_reset_released", dut_out(), mk_out(0, 0, 1, 2, 0, 0, 0));

    // Randomized against the reference model
    for (int n = 0; n < 400; n++) begin
      @(negedge clock);
      v.rst   = ($urandom_range(0, 24) == 0);
      v.sig   = 8'($urandom());
      v.id_rs = 5'($urandom_range(0, 3)); v.id_rt = 5'($urandom_range(0, 3));
      v.ex_rs = 5'($urandom_range(0, 3)); v.ex_rt = 5'($urandom_range(0, 3));
      v.ex_rd = 5'($urandom_range(0, 3)); v.me_rd = 5'($urandom_range(0, 3));
      v.wb_rd = 5'($urandom_range(0, 3));
      v.jl    = ($urandom_range(0, 7) == 0);
      v.ex_wr = 1'($urandom()); v.me_wr = 1'($urandom()); v.wb_wr = 1'($urandom());
      v.mr    = 1'($urandom()); v.mw = 1'($urandom()); v.m2r = 1'($urandom());
      drive(v);
      #1;
      check($sformatf("random_%0d", n), dut_out(), model(v));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
